// File: rtl/elelock_pkg.sv
// Shared types and key-decoding helpers for the programmable electronic lock.
package elelock_pkg;

    typedef enum logic [1:0] {
        ST_LOCKED,
        ST_OPEN,
        ST_PROG,
        ST_LOCKOUT
    } state_t;

    localparam logic [3:0] BLANK = 4'hF;

    function automatic logic is_onehot10(input logic [9:0] k);
        return $countones(k) == 1;
    endfunction

    function automatic logic [3:0] onehot10_to_bcd(input logic [9:0] k);
        logic [3:0] d;
        d = BLANK;
        for (int i = 0; i < 10; i++)
            if (k[i]) d = 4'(i);
        return d;
    endfunction

endpackage

// File: rtl/tenkey_enc.sv
// Ten-key front end: one press per key-down from an idle pad, multi-key ignored.
module tenkey_enc
    import elelock_pkg::*;
(
    input  logic       ck,
    input  logic       reset,
    input  logic [9:0] tenkey_i,
    output logic       press_vld_o,
    output logic [3:0] digit_o
);

    logic [9:0] key_q;

    always_ff @(posedge ck) begin
        if (!reset) key_q <= '0;
        else        key_q <= tenkey_i;
    end

    // Requiring an idle previous sample turns a held key into a single press.
    assign press_vld_o = is_onehot10(tenkey_i) && (key_q == '0);
    assign digit_o     = onehot10_to_bcd(tenkey_i);

endmodule

// File: rtl/elelock_prog.sv
// Lock controller: digit buffer, reprogrammable code, fail counter with lockout, auto-relock.
module elelock_prog
    import elelock_pkg::*;
#(
    parameter int                  DIGITS       = 4,
    parameter logic [4*DIGITS-1:0] DEFAULT_CODE = 16'h5963,
    parameter int                  MAX_FAIL     = 3,
    parameter int                  LOCKOUT_CYC  = 16,
    parameter int                  RELOCK_CYC   = 32,
    localparam int                 FW           = $clog2(MAX_FAIL + 1)
) (
    input  logic          ck,
    input  logic          reset,
    input  logic [9:0]    tenkey,
    input  logic          close,
    input  logic          prog,
    output logic          lock,
    output logic          alarm,
    output logic          prog_md,
    output logic [FW-1:0] fails
);

    localparam int TMAX = (LOCKOUT_CYC > RELOCK_CYC) ? LOCKOUT_CYC : RELOCK_CYC;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam int CW   = $clog2(DIGITS + 1);

    localparam logic [TW-1:0] RELOCK_LAST  = TW'(RELOCK_CYC - 1);
    localparam logic [TW-1:0] LOCKOUT_LAST = TW'(LOCKOUT_CYC - 1);
    localparam logic [CW-1:0] CNT_FULL     = CW'(DIGITS);
    localparam logic [FW-1:0] FAIL_MAX     = FW'(MAX_FAIL);

    state_t                   state_q;
    logic [DIGITS-1:0][3:0]   dbuf_q;
    logic [DIGITS-1:0][3:0]   dbuf_shift_d;
    logic [4*DIGITS-1:0]      code_q;
    logic [CW-1:0]            cnt_q;
    logic [TW-1:0]            timer_q;
    logic                     press;
    logic [3:0]               digit;

    tenkey_enc u_enc (
        .ck          (ck),
        .reset       (reset),
        .tenkey_i    (tenkey),
        .press_vld_o (press),
        .digit_o     (digit)
    );

    // Newest digit lands in dbuf[0]; dbuf[DIGITS-1] holds the first entered (MS) digit.
    always_comb begin
        dbuf_shift_d[0] = digit;
        for (int i = 1; i < DIGITS; i++)
            dbuf_shift_d[i] = dbuf_q[i-1];
    end

    always_ff @(posedge ck) begin
        if (!reset) begin
            state_q <= ST_LOCKED;
            lock    <= 1'b1;
            alarm   <= 1'b0;
            prog_md <= 1'b0;
            fails   <= '0;
            dbuf_q  <= {DIGITS{BLANK}};
            cnt_q   <= '0;
            timer_q <= '0;
            code_q  <= DEFAULT_CODE;
        end else begin
            case (state_q)
                ST_LOCKED: begin
                    if (cnt_q == CNT_FULL) begin
                        dbuf_q <= {DIGITS{BLANK}};
                        cnt_q  <= '0;
                        if (dbuf_q == code_q) begin
                            state_q <= ST_OPEN;
                            lock    <= 1'b0;
                            fails   <= '0;
                            timer_q <= '0;
                        end else if (fails == FAIL_MAX - 1'b1) begin
                            state_q <= ST_LOCKOUT;
                            alarm   <= 1'b1;
                            fails   <= FAIL_MAX;
                            timer_q <= '0;
                        end else begin
                            fails <= fails + 1'b1;
                        end
                    end else if (press) begin
                        dbuf_q <= dbuf_shift_d;
                        cnt_q  <= cnt_q + 1'b1;
                    end
                end
                ST_OPEN: begin
                    dbuf_q <= {DIGITS{BLANK}};
                    cnt_q  <= '0;
                    if (close) begin
                        state_q <= ST_LOCKED;
                        lock    <= 1'b1;
                    end else if (prog) begin
                        state_q <= ST_PROG;
                        prog_md <= 1'b1;
                    end else if (timer_q == RELOCK_LAST) begin
                        state_q <= ST_LOCKED;
                        lock    <= 1'b1;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                ST_PROG: begin
                    if (close) begin
                        state_q <= ST_LOCKED;
                        lock    <= 1'b1;
                        prog_md <= 1'b0;
                        dbuf_q  <= {DIGITS{BLANK}};
                        cnt_q   <= '0;
                    end else if (cnt_q == CNT_FULL) begin
                        code_q  <= dbuf_q;
                        state_q <= ST_OPEN;
                        prog_md <= 1'b0;
                        timer_q <= '0;
                        dbuf_q  <= {DIGITS{BLANK}};
                        cnt_q   <= '0;
                    end else if (press) begin
                        dbuf_q <= dbuf_shift_d;
                        cnt_q  <= cnt_q + 1'b1;
                    end
                end
                ST_LOCKOUT: begin
                    if (timer_q == LOCKOUT_LAST) begin
                        state_q <= ST_LOCKED;
                        alarm   <= 1'b0;
                        fails   <= '0;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_LOCKED;
                    lock    <= 1'b1;
                    alarm   <= 1'b0;
                    prog_md <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_elelock_prog.sv
// Directed scenarios plus random traffic, every cycle checked against a digit-queue model.
module tb_elelock_prog;

    localparam int                 DIGITS       = 4;
    localparam logic [4*DIGITS-1:0] DEFAULT_CODE = 16'h5963;
    localparam int                 MAX_FAIL     = 3;
    localparam int                 LOCKOUT_CYC  = 16;
    localparam int                 RELOCK_CYC   = 32;
    localparam int                 FW           = $clog2(MAX_FAIL + 1);

    localparam int M_SHUT = 0, M_OPEN = 1, M_PROG = 2, M_ALARM = 3;

    logic          ck = 1'b0;
    logic          rst = 1'b0;
    logic [9:0]    tk = '0;
    logic          cl = 1'b0;
    logic          pr = 1'b0;
    logic          lock, alarm, prog_md;
    logic [FW-1:0] fails;

    int nvec = 0;
    int nerr = 0;

    // model: pending digits in entry order, secret code in entry order
    int         mode = M_SHUT;
    int         ent[$];
    int         secret[$];
    int         left = 0;
    int         nfail = 0;
    logic [9:0] prev_k = '0;

    elelock_prog #(
        .DIGITS      (DIGITS),
        .DEFAULT_CODE(DEFAULT_CODE),
        .MAX_FAIL    (MAX_FAIL),
        .LOCKOUT_CYC (LOCKOUT_CYC),
        .RELOCK_CYC  (RELOCK_CYC)
    ) dut (
        .ck     (ck),
        .reset  (rst),
        .tenkey (tk),
        .close  (cl),
        .prog   (pr),
        .lock   (lock),
        .alarm  (alarm),
        .prog_md(prog_md),
        .fails  (fails)
    );

    always #5 ck = ~ck;

    task automatic chk(input string tag, input int got, input int exp);
        nvec++;
        if (got != exp) begin
            nerr++;
            $display("FAIL %s got %0d exp %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit ent_matches();
        if (ent.size() != secret.size()) return 1'b0;
        foreach (ent[i]) if (ent[i] != secret[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_step();
        logic [4*DIGITS-1:0] dc;
        bit press;
        int dig;
        if (!rst) begin
            mode  = M_SHUT;
            ent.delete();
            secret.delete();
            dc = DEFAULT_CODE;
            for (int i = DIGITS - 1; i >= 0; i--) secret.push_back(int'(dc[4*i +: 4]));
            nfail = 0;
            left  = 0;
            prev_k = '0;
            return;
        end
        press = ($countones(tk) == 1) && (prev_k == '0);
        dig = 0;
        for (int i = 0; i < 10; i++) if (tk[i]) dig = i;
        prev_k = tk;
        case (mode)
            M_SHUT: begin
                if (ent.size() == DIGITS) begin
                    if (ent_matches()) begin
                        mode = M_OPEN; left = RELOCK_CYC; nfail = 0;
                    end else begin
                        nfail++;
                        if (nfail == MAX_FAIL) begin mode = M_ALARM; left = LOCKOUT_CYC; end
                    end
                    ent.delete();
                end else if (press) ent.push_back(dig);
            end
            M_OPEN: begin
                if (cl)      begin mode = M_SHUT; ent.delete(); end
                else if (pr) begin mode = M_PROG; ent.delete(); end
                else begin
                    left--;
                    if (left == 0) begin mode = M_SHUT; ent.delete(); end
                end
            end
            M_PROG: begin
                if (cl) begin mode = M_SHUT; ent.delete(); end
                else if (ent.size() == DIGITS) begin
                    secret = ent;
                    ent.delete();
                    mode = M_OPEN; left = RELOCK_CYC;
                end else if (press) ent.push_back(dig);
            end
            default: begin
                left--;
                if (left == 0) begin mode = M_SHUT; nfail = 0; end
            end
        endcase
    endtask

    task automatic tick();
        @(posedge ck);
        model_step();
        #1;
        chk("lock",    int'(lock),    (mode == M_SHUT || mode == M_ALARM) ? 1 : 0);
        chk("alarm",   int'(alarm),   (mode == M_ALARM) ? 1 : 0);
        chk("prog_md", int'(prog_md), (mode == M_PROG) ? 1 : 0);
        chk("fails",   int'(fails),   nfail);
    endtask

    task automatic key(input int d, input int hold = 4, input int gap = 4);
        tk = 10'(1 << d);
        repeat (hold) tick();
        tk = '0;
        repeat (gap) tick();
    endtask

    task automatic enter(input int a, input int b, input int c, input int d,
                         input int hold = 4, input int gap = 4);
        key(a, hold, gap); key(b, hold, gap); key(c, hold, gap); key(d, hold, gap);
    endtask

    task automatic pulse_close();
        cl = 1'b1; tick(); cl = 1'b0; tick();
    endtask

    initial begin
        int n, r, hold, gap;
        int sc[$];

        // 1: reset values, open with default code, one-cycle latency
        rst = 1'b0; tick(); tick();
        chk("rst_lock", int'(lock), 1);
        chk("rst_alarm", int'(alarm), 0);
        chk("rst_prog", int'(prog_md), 0);
        chk("rst_fails", int'(fails), 0);
        rst = 1'b1; tick();
        key(5); key(9); key(6);
        tk = 10'(1 << 3);
        tick();
        chk("t1_pre", int'(lock), 1);
        tick();
        chk("t1_open", int'(lock), 0);
        tk = '0;

        // 2: automatic relock exactly RELOCK_CYC cycles after opening
        n = 0;
        while (lock == 1'b0 && n < 100) begin tick(); n++; end
        chk("t2_relock", n, RELOCK_CYC);

        // 3: three wrong codes, lockout ignores keys, then the default code opens
        enter(1, 1, 1, 1);
        chk("t3_f1", int'(fails), 1);
        enter(1, 1, 1, 1);
        chk("t3_f2", int'(fails), 2);
        enter(1, 1, 1, 1);
        chk("t3_alarm", int'(alarm), 1);
        enter(5, 9, 6, 3, 1, 1);
        chk("t3_lo_lock", int'(lock), 1);
        n = 0;
        while (alarm == 1'b1 && n < 40) begin tick(); n++; end
        chk("t3_lo_end", int'(alarm), 0);
        chk("t3_f0", int'(fails), 0);
        enter(5, 9, 6, 3);
        chk("t3_open", int'(lock), 0);

        // 4: reprogram to 2468
        pr = 1'b1; tick(); pr = 1'b0; tick();
        chk("t4_pmd", int'(prog_md), 1);
        enter(2, 4, 6, 8);
        chk("t4_pmd0", int'(prog_md), 0);
        chk("t4_open", int'(lock), 0);
        pulse_close();
        chk("t4_close", int'(lock), 1);
        enter(5, 9, 6, 3);
        chk("t4_old", int'(fails), 1);
        chk("t4_oldlk", int'(lock), 1);
        enter(2, 4, 6, 8);
        chk("t4_new", int'(lock), 0);

        // 5: multi-key ignored, long hold is one digit, close+key in OPEN
        cl = 1'b1; tk = 10'(1 << 7); tick(); cl = 1'b0; tk = '0; tick();
        chk("t5_cls", int'(lock), 1);
        tk = 10'h009; repeat (3) tick(); tk = '0; repeat (2) tick();
        key(2, 20, 4); key(4); key(6); key(8);
        chk("t5_open", int'(lock), 0);
        chk("t5_f0", int'(fails), 0);

        // 6: reset mid-PROG restores the default code
        pr = 1'b1; tick(); pr = 1'b0; tick();
        key(1); key(2);
        rst = 1'b0; tick();
        chk("t6_lock", int'(lock), 1);
        chk("t6_pmd", int'(prog_md), 0);
        chk("t6_fails", int'(fails), 0);
        rst = 1'b1; tick();
        enter(1, 2, 0, 0);
        chk("t6_part", int'(lock), 1);
        enter(5, 9, 6, 3);
        chk("t6_dflt", int'(lock), 0);
        pulse_close();

        // random traffic
        for (int it = 0; it < 300; it++) begin
            r = $urandom_range(0, 9);
            hold = $urandom_range(1, 3);
            gap  = $urandom_range(0, 2);
            case (r)
                0, 1, 2: begin
                    sc = secret;
                    foreach (sc[i]) key(sc[i], hold, gap);
                end
                3, 4: repeat (DIGITS) key($urandom_range(0, 9), hold, gap);
                5: begin cl = 1'b1; repeat ($urandom_range(1, 3)) tick(); cl = 1'b0; end
                6: begin
                    pr = 1'b1; tick(); pr = 1'b0;
                    if ($urandom_range(0, 1) == 1)
                        repeat (DIGITS) key($urandom_range(0, 9), hold, gap);
                end
                7: begin
                    repeat ($urandom_range(1, 6)) begin
                        tk = 10'($urandom);
                        cl = ($urandom_range(0, 7) == 0);
                        tick();
                    end
                    tk = '0; cl = 1'b0; tick();
                end
                8: repeat ($urandom_range(0, 40)) tick();
                default: if ($urandom_range(0, 3) == 0) begin
                    rst = 1'b0; tick(); rst = 1'b1; tick();
                end else tick();
            endcase
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
